hex_char_serializer: RTL and testbench
======================================

// Module: hex_char_serializer
// PURPOSE
//   Sequences binary-to-hex ASCII conversion for a debug/console byte stream.
//   Accepts an N-bit word over a valid/ready handshake and emits its hex digits
//   one ASCII byte per handshake, MSB nibble first, optionally followed by CR LF.
//   Sits between a status/trace word source and a UART TX byte FIFO.
// PARAMETERS
//   N              32  input word width; must be a multiple of 4, >= 4
//   APPEND_NEWLINE 1   1: append 8'h0D, 8'h0A after the last digit; 0: digits only
//   UPPERCASE      1   1: digits A-F are 8'h41-46; 0: a-f are 8'h61-66
// PORTS
//   clk       in   1  single clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   in_valid  in   1  in_data holds a word to convert
//   in_ready  out  1  block is idle and can accept a word
//   in_data   in   N  binary word to convert
//   out_valid out  1  out_char holds a valid ASCII byte
//   out_ready in   1  downstream accepts out_char this cycle
//   out_char  out  8  ASCII byte being offered
//   out_last  out  1  out_char is the final byte of the current word's record
//   busy      out  1  a word is captured and not yet fully emitted
// BEHAVIOUR
//   Reset state: in_ready=1, out_valid=0, out_last=0, busy=0, out_char=8'h00.
//   FSM states: IDLE, DIGIT, CR, LF.
//   - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: capture in_data into
//     shift register, load digit counter with N/4-1, go to DIGIT.
//   - DIGIT: out_valid=1, out_char=ascii(shreg[N-1 -: 4]). On out_valid&&out_ready:
//     if counter==0, go to CR (APPEND_NEWLINE=1) or IDLE (APPEND_NEWLINE=0);
//     otherwise shift shreg left 4 and decrement counter.
//   - CR: out_char=8'h0D; on handshake go to LF.
//   - LF: out_char=8'h0A; on handshake go to IDLE.
//   out_last=1 in LF, or in DIGIT with counter==0 when APPEND_NEWLINE=0.
//   Latency: word accepted at edge k -> first digit valid after edge k.
//   Throughput: 1 byte/cycle under continuous out_ready. Record length is
//   N/4+2 bytes (N/4 bytes without newline).
//   Inter-record gap: in_ready rises the cycle after the final handshake.
//   Back-to-back words have one bubble cycle.
//   out_char, out_last and out_valid must stay stable while out_valid && !out_ready.
//   out_char is decoded from registered state only; no in_data->out path.
//   in_ready = (state==IDLE); no in_ready->in_valid combinational dependency.
//   in_valid while busy: ignored, in_data not sampled; source must hold it.
//   busy = (state!=IDLE).
//   Counter width is max(1,$clog2(N/4)). For N=4, counter is 1 bit and only 0 is used.
//   Reset asserted mid-record: current word discarded, outputs go to reset values
//   immediately (async). No partial record resumes after reset.
//   Nibble decode is total over 0-F; there is no error/"X" character.
// STRUCTURE
//   Shared package hex_pkg: localparams ASCII_CR=8'h0D, ASCII_LF=8'h0A,
//   ASCII_0=8'h30, ASCII_A_UC=8'h41, ASCII_A_LC=8'h61; FSM state encoding
//   (2-bit IDLE/DIGIT/CR/LF).
//   One sub-module: nibble_to_ascii (combinational, param UPPERCASE,
//   in [3:0] -> out [7:0]), shared with other hex display blocks.
//   Top contains FSM, shift register and digit counter.
// TESTING
//   1. N=32, in_data=32'h1234ABCD, out_ready=1 -> bytes
//      "1","2","3","4","A","B","C","D",0D,0A on 10 consecutive cycles;
//      out_last only on 0A; in_ready returns 1 the following cycle.
//   2. Same word, out_ready toggling 1010.. then held low 5 cycles
//      -> identical byte sequence; out_char/out_last stable while stalled.
//   3. N=8, UPPERCASE=0, APPEND_NEWLINE=0, in_data=8'hFE -> "f","e";
//      out_last on "e"; no CR/LF.
//   4. in_valid held high with 32'h00000000 then 32'hFFFFFFFF
//      -> "00000000\r\n" then "FFFFFFFF\r\n"; second word accepted only in IDLE.
//      Exactly one bubble between records.
//   5. rst_n pulsed low after 3rd digit of 32'hDEADBEEF -> out_valid drops
//      asynchronously, in_ready=1. Next word 32'h00000001 emits "00000001\r\n"
//      with no residual "DEA..." bytes.
//   6. N=4, in_data=4'h9 -> "9",0D,0A; counter does not underflow.

Source files
------------

// File: rtl/hex_pkg.sv
// ---------------------------------------------------------------------------
// hex_pkg
//   Shared constants and types for the hex display / console blocks.
//
//   Contents:
//     ASCII_*      byte values used when rendering hex digits and line endings
//     hex_state_e  2-bit state encoding of the hex character serializer
//     cnt_width()  width of a digit counter that must hold 0 .. digits-1
// ---------------------------------------------------------------------------
package hex_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

    // IDLE  : waiting for a word
    // DIGIT : offering hex digits, MSB nibble first
    // CR/LF : offering the line terminator bytes
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_CR    = 2'd2,
        ST_LF    = 2'd3
    } hex_state_e;

    // A single-digit record still needs a 1-bit counter; $clog2(1) is 0.
    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// ---------------------------------------------------------------------------
// nibble_to_ascii
//   Combinational conversion of one 4-bit value to its ASCII hex digit.
//   The mapping is total: every nibble 0-F has a printable character.
//
//   Parameters:
//     UPPERCASE  1: 10-15 -> 'A'-'F' (8'h41-46); 0: 'a'-'f' (8'h61-66)
//
//   Ports:
//     nibble  in  4  value to convert
//     ascii   out 8  ASCII character for nibble
// ---------------------------------------------------------------------------
module nibble_to_ascii
    import hex_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    localparam logic [7:0] ALPHA_BASE = UPPERCASE ? ASCII_A_UC : ASCII_A_LC;

    always_comb begin
        ascii = ASCII_0;
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'h0, nibble};
        end else begin
            // Offset from the letter base so 10 lands on 'A' / 'a'.
            ascii = ALPHA_BASE + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_char_serializer.sv
// ---------------------------------------------------------------------------
// hex_char_serializer
//   Converts an N-bit word into a stream of ASCII hex digits, one byte per
//   output handshake, most significant nibble first, optionally followed by
//   CR LF. Intended to sit between a status/trace word source and a UART TX
//   byte FIFO.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. A source holding valid must keep its data
//   stable until the transfer. This block never makes a ready depend
//   combinationally on the matching valid, and once out_valid is raised,
//   out_char / out_last / out_valid hold until out_ready is seen.
//
//   Parameters:
//     N               word width, multiple of 4, >= 4
//     APPEND_NEWLINE  1: follow the digits with 8'h0D 8'h0A
//     UPPERCASE       1: A-F uppercase, 0: lowercase
//
//   Ports:
//     clk        in   1  rising-edge clock
//     rst_n      in   1  asynchronous active-low reset
//     in_valid   in   1  in_data holds a word to convert
//     in_ready   out  1  idle, can accept a word
//     in_data    in   N  word to convert
//     out_valid  out  1  out_char holds a valid byte
//     out_ready  in   1  downstream takes out_char this cycle
//     out_char   out  8  ASCII byte offered
//     out_last   out  1  out_char is the final byte of the record
//     busy       out  1  a word is captured and not fully emitted
//     dbg_state  out  2  current FSM state (hex_state_e encoding)
// ---------------------------------------------------------------------------
module hex_char_serializer
    import hex_pkg::*;
#(
    parameter int N              = 32,
    parameter bit APPEND_NEWLINE = 1'b1,
    parameter bit UPPERCASE      = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_char,
    output logic         out_last,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int              DIGITS   = N / 4;
    localparam int              CW       = cnt_width(DIGITS);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(DIGITS - 1);

    // Reject illegal widths at elaboration rather than emitting garbage.
    if ((N % 4) != 0 || N < 4) begin : g_bad_width
        $error("hex_char_serializer: N must be a multiple of 4 and >= 4");
    end

    hex_state_e     state_q;
    hex_state_e     state_d;
    logic [N-1:0]   shreg_q;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     digit_char;
    logic           last_digit;
    logic           accept;
    logic           advance;

    // The digit shown is always the top nibble of the captured word, so the
    // output path starts at registers only.
    nibble_to_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_nibble_to_ascii (
        .nibble (shreg_q[N-1 -: 4]),
        .ascii  (digit_char)
    );

    assign last_digit = (cnt_q == '0);
    assign accept     = in_valid && (state_q == ST_IDLE);
    // Shift only on a digit handshake that is not the final digit; after the
    // final digit the counter stays at zero, so it never wraps.
    assign advance    = (state_q == ST_DIGIT) && out_ready && !last_digit;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                if (out_ready && last_digit) begin
                    state_d = APPEND_NEWLINE ? ST_CR : ST_IDLE;
                end
            end
            ST_CR: begin
                if (out_ready) begin
                    state_d = ST_LF;
                end
            end
            ST_LF: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (registered state only)
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_char  = 8'h00;
        out_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                out_valid = 1'b0;
            end
            ST_DIGIT: begin
                out_valid = 1'b1;
                out_char  = digit_char;
                out_last  = last_digit && (APPEND_NEWLINE == 1'b0);
            end
            ST_CR: begin
                out_valid = 1'b1;
                out_char  = ASCII_CR;
            end
            ST_LF: begin
                out_valid = 1'b1;
                out_char  = ASCII_LF;
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    // -----------------------------------------------------------------------
    // Shift register and digit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            shreg_q <= in_data;
            cnt_q   <= CNT_LOAD;
        end else if (advance) begin
            shreg_q <= shreg_q << 4;
            cnt_q   <= cnt_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_hex_char_serializer.sv
// ---------------------------------------------------------------------------
// tb_hex_char_serializer
//   Three instances: 32-bit uppercase with CR LF, 8-bit lowercase without
//   newline, and 4-bit uppercase with CR LF. Expected bytes ({last,char}) are
//   queued when a word is accepted and popped on each output handshake.
// ---------------------------------------------------------------------------
module tb_hex_char_serializer;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 32-bit instance
    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, ol32, b32;
    logic [31:0] id32 = '0;
    logic [7:0]  oc32;
    logic [1:0]  st32;
    // 8-bit instance
    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, ol8, b8;
    logic [7:0]  id8 = '0;
    logic [7:0]  oc8;
    logic [1:0]  st8;
    // 4-bit instance
    logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, ol4, b4;
    logic [3:0]  id4 = '0;
    logic [7:0]  oc4;
    logic [1:0]  st4;

    hex_char_serializer #(.N(32), .APPEND_NEWLINE(1'b1), .UPPERCASE(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .out_valid(ov32), .out_ready(or32), .out_char(oc32), .out_last(ol32),
        .busy(b32), .dbg_state(st32));

    hex_char_serializer #(.N(8), .APPEND_NEWLINE(1'b0), .UPPERCASE(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .out_char(oc8), .out_last(ol8),
        .busy(b8), .dbg_state(st8));

    hex_char_serializer #(.N(4), .APPEND_NEWLINE(1'b1), .UPPERCASE(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_char(oc4), .out_last(ol4),
        .busy(b4), .dbg_state(st4));

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    logic [8:0]  exp32_q[$];
    logic [8:0]  exp8_q[$];
    logic [8:0]  exp4_q[$];
    logic [31:0] words32[$];

    int acc_first, acc_last, fire_last;

    function automatic logic [7:0] hex_char(input logic [3:0] nib, input bit uc);
        string s;
        s = uc ? "0123456789ABCDEF" : "0123456789abcdef";
        return s[int'(nib)];
    endfunction

    task automatic push_word32(input logic [31:0] w);
        for (int i = 7; i >= 0; i--) exp32_q.push_back({1'b0, hex_char(w[4*i +: 4], 1'b1)});
        exp32_q.push_back({1'b0, 8'h0D});
        exp32_q.push_back({1'b1, 8'h0A});
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0: return 1'b1;
            1: return (cyc < 8) ? ((cyc % 2) == 0) : ((cyc < 13) ? 1'b0 : 1'b1);
            default: return 1'b1 & $urandom_range(0, 1);
        endcase
    endfunction

    // Drives pending words32 (in_valid held while any remain) and drains the
    // 32-bit instance until both sides are empty, or until stop_after bytes.
    task automatic run_stream32(input int mode, input int stop_after, input int budget);
        int         cyc = 0;
        int         fired = 0;
        bit         fired_now;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_char = '0;
        logic       prev_last = 1'b0;
        logic [8:0] exp;
        bit         pending;
        acc_first = -1; acc_last = -1; fire_last = -1;
        forever begin
            if (cyc >= budget) begin
                checks++; failures++;
                $display("FAIL stream32_timeout words_left=%0d bytes_left=%0d", words32.size(), exp32_q.size());
                break;
            end
            @(negedge clk);
            iv32 = (words32.size() != 0);
            if (iv32) id32 = words32[0];
            or32 = pick_ready(mode, cyc);
            #1;
            fired_now = 1'b0;
            if (prev_stall) begin
                checks++;
                if ({ov32, oc32, ol32} !== {1'b1, prev_char, prev_last}) begin
                    failures++;
                    $display("FAIL stall_hold got v=%b c=%h l=%b exp v=1 c=%h l=%b", ov32, oc32, ol32, prev_char, prev_last);
                end
            end
            pending = (exp32_q.size() != 0);
            checks++;
            if ({ir32, ov32, b32} !== {!pending, pending, pending}) begin
                failures++;
                $display("FAIL idle_flags cyc=%0d got ready=%b valid=%b busy=%b exp ready=%b valid=%b busy=%b",
                         cyc, ir32, ov32, b32, !pending, pending, pending);
            end
            if (ov32 && or32) begin
                checks++;
                if (exp32_q.size() == 0) begin
                    failures++;
                    $display("FAIL byte32_extra got=%h last=%b exp=none", oc32, ol32);
                end else begin
                    exp = exp32_q.pop_front();
                    if ({ol32, oc32} !== exp) begin
                        failures++;
                        $display("FAIL byte32 got last=%b char=%h exp last=%b char=%h", ol32, oc32, exp[8], exp[7:0]);
                    end
                end
                fired++;
                fired_now = 1'b1;
                fire_last = cyc;
            end
            if (iv32 && ir32) begin
                push_word32(words32.pop_front());
                if (acc_first < 0) acc_first = cyc;
                acc_last = cyc;
            end
            prev_stall = ov32 && !or32;
            prev_char  = oc32;
            prev_last  = ol32;
            cyc++;
            if (stop_after != 0 && fired == stop_after) break;
            if (!fired_now && words32.size() == 0 && exp32_q.size() == 0) break;
        end
        iv32 = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ir32, ov32, ol32, b32, oc32, st32} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0}) begin
            failures++;
            $display("FAIL reset32 got ready=%b valid=%b last=%b busy=%b char=%h st=%0d exp 1 0 0 0 00 0",
                     ir32, ov32, ol32, b32, oc32, st32);
        end
        checks++;
        if ({ir8, ov8, b8, ir4, ov4, b4} !== 6'b100_100) begin
            failures++;
            $display("FAIL reset_small got %b exp 100100", {ir8, ov8, b8, ir4, ov4, b4});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        words32.push_back(32'h1234ABCD);
        run_stream32(0, 0, 40);
        checks++;
        if (fire_last - acc_first != 10) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=10", fire_last - acc_first);
        end
    endtask

    task automatic test_stall;
        words32.push_back(32'h1234ABCD);
        run_stream32(1, 0, 60);
    endtask

    task automatic test_back_to_back;
        words32.push_back(32'h00000000);
        words32.push_back(32'hFFFFFFFF);
        run_stream32(0, 0, 60);
        checks++;
        if (acc_last - acc_first != 11 || fire_last - acc_last != 10) begin
            failures++;
            $display("FAIL b2b_spacing got acc_gap=%0d tail=%0d exp acc_gap=11 tail=10",
                     acc_last - acc_first, fire_last - acc_last);
        end
    endtask

    task automatic test_random_ready;
        for (int i = 0; i < 4; i++) words32.push_back($urandom());
        run_stream32(2, 0, 400);
    endtask

    task automatic test_reset_mid_record;
        words32.push_back(32'hDEADBEEF);
        run_stream32(0, 3, 40);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov32, ir32, b32, ol32, oc32} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL async_reset got valid=%b ready=%b busy=%b last=%b char=%h exp 0 1 0 0 00",
                     ov32, ir32, b32, ol32, oc32);
        end
        exp32_q.delete();
        words32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        words32.push_back(32'h00000001);
        run_stream32(0, 0, 40);
    endtask

    task automatic test_n8_lowercase;
        logic [8:0] exp;
        @(negedge clk);
        iv8 = 1'b1; id8 = 8'hFE; or8 = 1'b1;
        #1;
        checks++;
        if (ir8 !== 1'b1) begin
            failures++;
            $display("FAIL n8_ready got=%b exp=1", ir8);
        end
        exp8_q.push_back({1'b0, hex_char(4'hF, 1'b0)});
        exp8_q.push_back({1'b1, hex_char(4'hE, 1'b0)});
        for (int c = 0; c < 6 && exp8_q.size() != 0; c++) begin
            @(negedge clk);
            iv8 = 1'b0;
            #1;
            if (ov8) begin
                exp = exp8_q.pop_front();
                checks++;
                if ({ol8, oc8} !== exp) begin
                    failures++;
                    $display("FAIL n8_byte got last=%b char=%h exp last=%b char=%h", ol8, oc8, exp[8], exp[7:0]);
                end
            end
        end
        checks++;
        if (exp8_q.size() != 0) begin
            failures++;
            $display("FAIL n8_timeout got left=%0d exp=0", exp8_q.size());
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ov8, ir8} !== 2'b01) begin
            failures++;
            $display("FAIL n8_no_newline got valid=%b ready=%b exp valid=0 ready=1", ov8, ir8);
        end
    endtask

    task automatic test_n4_single;
        logic [8:0] exp;
        logic [3:0] vals[2];
        vals[0] = 4'h9;
        vals[1] = 4'hA;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            iv4 = 1'b1; id4 = vals[w]; or4 = 1'b1;
            #1;
            checks++;
            if (ir4 !== 1'b1) begin
                failures++;
                $display("FAIL n4_ready got=%b exp=1", ir4);
            end
            exp4_q.push_back({1'b0, hex_char(vals[w], 1'b1)});
            exp4_q.push_back({1'b0, 8'h0D});
            exp4_q.push_back({1'b1, 8'h0A});
            for (int c = 0; c < 8 && exp4_q.size() != 0; c++) begin
                @(negedge clk);
                iv4 = 1'b0;
                #1;
                if (ov4) begin
                    exp = exp4_q.pop_front();
                    checks++;
                    if ({ol4, oc4} !== exp) begin
                        failures++;
                        $display("FAIL n4_byte got last=%b char=%h exp last=%b char=%h", ol4, oc4, exp[8], exp[7:0]);
                    end
                end
            end
            @(negedge clk);
            #1;
            checks++;
            if (exp4_q.size() != 0 || {ov4, ir4} !== 2'b01) begin
                failures++;
                $display("FAIL n4_end got left=%0d valid=%b ready=%b exp left=0 valid=0 ready=1",
                         exp4_q.size(), ov4, ir4);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_n8_lowercase();
        test_back_to_back();
        test_reset_mid_record();
        test_n4_single();
        test_random_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
